// File: rtl/hdmi_frame_packer.sv
// hdmi_frame_packer: captures one active RGB888 window per video frame in the
// pixel clock domain, splits pixels into R/G/B banks, packs PIXELS_PER_WORD
// samples per bank word, strobes the words out with addresses, and requests a
// buffer swap once per fully written frame.
module hdmi_frame_packer #(
  parameter int unsigned ADDRESS_DEPTH    = 512,
  parameter int unsigned BANK_COUNT       = 3,
  parameter int unsigned BLOCK_COUNT      = 4,
  parameter int unsigned BLOCK_DATA_WIDTH = 32,
  parameter int unsigned BANDWIDTH        = BLOCK_COUNT * BLOCK_DATA_WIDTH,
  parameter int unsigned PIXELS_PER_WORD  = BANDWIDTH / 8,
  parameter int unsigned FRAME_WIDTH      = 128,
  parameter int unsigned FRAME_HEIGHT     = 64
) (
  input  logic                                            clka,
  input  logic                                            rst_n,
  input  logic                                            vsync,
  input  logic                                            de,
  input  logic [23:0]                                     rgb,
  output logic [BANK_COUNT-1:0][$clog2(ADDRESS_DEPTH)-1:0] ada,
  output logic [BANK_COUNT-1:0][BANDWIDTH-1:0]            din,
  output logic                                            clk_data_in,
  output logic                                            swap_trigger,
  output logic                                            frame_drop,
  output logic [7:0]                                      frame_count
);

  localparam int unsigned AW  = $clog2(ADDRESS_DEPTH);
  localparam int unsigned WPL = FRAME_WIDTH / PIXELS_PER_WORD;
  localparam int unsigned PW  = $clog2(FRAME_WIDTH + 1);
  localparam int unsigned LW  = $clog2(FRAME_HEIGHT + 1);
  localparam int unsigned KW  = $clog2(PIXELS_PER_WORD);
  localparam int unsigned WW  = $clog2(WPL + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_SETTLE  = 2'd2;
  localparam logic [1:0] ST_SWAP    = 2'd3;

  typedef logic [BANK_COUNT-1:0][BANDWIDTH-1:0] bank_words_t;

  // Reject parameter sets the packing scheme cannot serve
  generate
    if (BANK_COUNT != 3) begin : g_bad_bank_count
      $error("hdmi_frame_packer: BANK_COUNT must be 3");
    end
    if (FRAME_WIDTH % PIXELS_PER_WORD != 0) begin : g_bad_width
      $error("hdmi_frame_packer: FRAME_WIDTH must be a multiple of PIXELS_PER_WORD");
    end
    if (ADDRESS_DEPTH < (FRAME_WIDTH * FRAME_HEIGHT) / PIXELS_PER_WORD) begin : g_bad_depth
      $error("hdmi_frame_packer: ADDRESS_DEPTH too small for one frame");
    end
  endgenerate

  // Input sync stage and edge-detect history
  logic        vsync_q, vsync_q2, de_q, de_q2;
  logic [23:0] rgb_q;

  // Control state
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pixel_cnt_q, pixel_cnt_d;
  logic [KW-1:0] slot_q, slot_d;
  logic [WW-1:0] word_cnt_q, word_cnt_d;
  logic [LW-1:0] line_cnt_q, line_cnt_d;
  logic [2:0]    settle_cnt_q, settle_cnt_d;
  logic          swap_cnt_q, swap_cnt_d;
  logic          pend_q, pend_d;

  // Datapath and output registers
  bank_words_t   pack_q, pack_d, word_c;
  bank_words_t   din_q, din_d;
  logic [AW-1:0] ada_q, ada_d;
  logic          wr_pulse_q, wr_pulse_d;
  logic          stb_q, stb_d;
  logic          clk_data_in_q, clk_data_in_d;
  logic          swap_trigger_q, swap_trigger_d;
  logic          frame_drop_q, frame_drop_d;
  logic [7:0]    frame_count_q, frame_count_d;

  logic vs_rise_c, de_fall_c, accept_c, word_done_c, stb_busy_c, clear_c;

  // Edge detection on the registered copies and pixel-accept qualification
  always_comb begin
    vs_rise_c   = vsync_q & ~vsync_q2;
    de_fall_c   = de_q2 & ~de_q;
    accept_c    = (state_q == ST_CAPTURE) && de_q &&
                  (pixel_cnt_q < PW'(FRAME_WIDTH)) &&
                  (line_cnt_q < LW'(FRAME_HEIGHT));
    word_done_c = accept_c && (slot_q == KW'(PIXELS_PER_WORD - 1));
    stb_busy_c  = wr_pulse_q | stb_q | clk_data_in_q;
  end

  // Current word with the incoming pixel merged into its slot, per bank
  always_comb begin
    word_c = pack_q;
    for (int b = 0; b < int'(BANK_COUNT); b++) begin
      word_c[b][{slot_q, 3'b000} +: 8] = rgb_q[8*(int'(BANK_COUNT)-1-b) +: 8];
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d        = state_q;
    pixel_cnt_d    = pixel_cnt_q;
    slot_d         = slot_q;
    word_cnt_d     = word_cnt_q;
    line_cnt_d     = line_cnt_q;
    settle_cnt_d   = settle_cnt_q;
    swap_cnt_d     = swap_cnt_q;
    pend_d         = pend_q;
    frame_drop_d   = 1'b0;
    frame_count_d  = frame_count_q;
    clear_c        = 1'b0;

    pack_d         = accept_c ? word_c : pack_q;
    din_d          = word_done_c ? word_c : din_q;
    ada_d          = word_done_c ? AW'(line_cnt_q * WPL + word_cnt_q) : ada_q;
    wr_pulse_d     = word_done_c;
    stb_d          = wr_pulse_q;
    clk_data_in_d  = wr_pulse_q | stb_q;

    case (state_q)
      ST_IDLE: begin
        if (vs_rise_c) begin
          state_d = ST_CAPTURE;
          clear_c = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (line_cnt_q == LW'(FRAME_HEIGHT)) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = 3'd0;
          pend_d       = vs_rise_c;
        end else if (vs_rise_c) begin
          frame_drop_d = 1'b1;
          clear_c      = 1'b1;
        end else begin
          if (accept_c) begin
            pixel_cnt_d = pixel_cnt_q + PW'(1);
            if (word_done_c) begin
              slot_d     = '0;
              word_cnt_d = word_cnt_q + WW'(1);
            end else begin
              slot_d = slot_q + KW'(1);
            end
          end
          // Line end: any partially filled word is dropped here
          if (de_fall_c) begin
            line_cnt_d  = line_cnt_q + LW'(1);
            pixel_cnt_d = '0;
            slot_d      = '0;
            word_cnt_d  = '0;
          end
        end
      end
      ST_SETTLE: begin
        if (vs_rise_c) pend_d = 1'b1;
        if (stb_busy_c) begin
          settle_cnt_d = 3'd0;
        end else if (settle_cnt_q == 3'd3) begin
          state_d    = ST_SWAP;
          swap_cnt_d = 1'b0;
        end else begin
          settle_cnt_d = settle_cnt_q + 3'd1;
        end
      end
      ST_SWAP: begin
        if (vs_rise_c) pend_d = 1'b1;
        if (swap_cnt_q) begin
          frame_count_d = frame_count_q + 8'd1;
          pend_d        = 1'b0;
          if (pend_q | vs_rise_c) begin
            state_d = ST_CAPTURE;
            clear_c = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          swap_cnt_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear_c) begin
      pixel_cnt_d = '0;
      slot_d      = '0;
      word_cnt_d  = '0;
      line_cnt_d  = '0;
    end

    swap_trigger_d = (state_d == ST_SWAP);
  end

  // State, counters and registered outputs
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q        <= 1'b0;
      vsync_q2       <= 1'b0;
      de_q           <= 1'b0;
      de_q2          <= 1'b0;
      rgb_q          <= '0;
      state_q        <= ST_IDLE;
      pixel_cnt_q    <= '0;
      slot_q         <= '0;
      word_cnt_q     <= '0;
      line_cnt_q     <= '0;
      settle_cnt_q   <= '0;
      swap_cnt_q     <= 1'b0;
      pend_q         <= 1'b0;
      pack_q         <= '0;
      din_q          <= '0;
      ada_q          <= '0;
      wr_pulse_q     <= 1'b0;
      stb_q          <= 1'b0;
      clk_data_in_q  <= 1'b0;
      swap_trigger_q <= 1'b0;
      frame_drop_q   <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      vsync_q        <= vsync;
      vsync_q2       <= vsync_q;
      de_q           <= de;
      de_q2          <= de_q;
      rgb_q          <= rgb;
      state_q        <= state_d;
      pixel_cnt_q    <= pixel_cnt_d;
      slot_q         <= slot_d;
      word_cnt_q     <= word_cnt_d;
      line_cnt_q     <= line_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
      swap_cnt_q     <= swap_cnt_d;
      pend_q         <= pend_d;
      pack_q         <= pack_d;
      din_q          <= din_d;
      ada_q          <= ada_d;
      wr_pulse_q     <= wr_pulse_d;
      stb_q          <= stb_d;
      clk_data_in_q  <= clk_data_in_d;
      swap_trigger_q <= swap_trigger_d;
      frame_drop_q   <= frame_drop_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign ada          = {BANK_COUNT{ada_q}};
  assign din          = din_q;
  assign clk_data_in  = clk_data_in_q;
  assign swap_trigger = swap_trigger_q;
  assign frame_drop   = frame_drop_q;
  assign frame_count  = frame_count_q;

endmodule

// File: doc/hdmi_frame_packer.md
Name: hdmi_frame_packer

Overview:
- Upstream write-side stage of the matrix frame double buffer, running in the HDMI pixel clock domain (clka).
- Captures one active window of FRAME_WIDTH x FRAME_HEIGHT RGB888 pixels per video frame and splits each pixel into R/G/B banks.
- Packs 16 consecutive pixels per bank into one BANDWIDTH-bit word and issues write strobes with addresses.
- Issues one swap_trigger after each fully written frame; never swaps after an aborted frame.

Parameters:
- ADDRESS_DEPTH, 512: words per bank; must be ≥ FRAME_WIDTH*FRAME_HEIGHT/PIXELS_PER_WORD (elaboration error otherwise).
- BANK_COUNT, 3: banks; must equal 3 (bank0 = R, bank1 = G, bank2 = B).
- BLOCK_COUNT, 4: blocks per bank word.
- BLOCK_DATA_WIDTH, 32: bits per block.
- BANDWIDTH, BLOCK_COUNT*BLOCK_DATA_WIDTH: bits per bank word.
- PIXELS_PER_WORD, BANDWIDTH/8: 8-bit channel samples per word (16 at defaults).
- FRAME_WIDTH, 128: captured pixels per line; must be a multiple of PIXELS_PER_WORD.
- FRAME_HEIGHT, 64: captured lines per frame.

Ports:
- clka  in  1  pixel clock; sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- vsync  in  1  active-high frame sync, sampled on clka.
- de  in  1  active-high data enable; one pixel per clka while high.
- rgb  in  24  pixel; [23:16] R, [15:8] G, [7:0] B.
- ada  out  $clog2(ADDRESS_DEPTH) x BANK_COUNT  write address; all banks carry the same value.
- din  out  BANDWIDTH x BANK_COUNT  packed channel words.
- clk_data_in  out  1  write strobe.
- swap_trigger  out  1  buffer swap request.
- frame_drop  out  1  one-cycle pulse on an aborted frame.
- frame_count  out  8  completed frames; wraps 255→0.

Behaviour:
- Reset values: ada = 0, din = 0, clk_data_in = 0, swap_trigger = 0, frame_drop = 0, frame_count = 0; FSM in IDLE. Reset is async assert, sync release and aborts everything in flight.
- Edge detection: vsync and de are registered one stage; rise and fall are detected on the registered copies.
- Packing: within a word, pixel k of the group goes to din[b][8k+7:8k].
  - After the 16th pixel, the word and its address are registered into din/ada.
  - Address = line*(FRAME_WIDTH/PIXELS_PER_WORD) + word_index.
- Write strobe: clk_data_in goes high the cycle after the word is registered, stays high exactly 2 cycles, then low.
  - din/ada stay stable until the next word is registered, which is ≥16 cycles later. This meets the consumer's 2-flop edge detector and RAM latch.
- FSM states:
  - IDLE: wait for vsync rise → CAPTURE; clear pixel, word and line counters.
  - CAPTURE:
    - Accept pixels only while de = 1, pixel_cnt < FRAME_WIDTH, and line_cnt < FRAME_HEIGHT.
    - Pixels beyond FRAME_WIDTH are ignored.
    - de fall: line_cnt++, pixel and word counters clear. An incomplete trailing word is discarded, not written.
    - When line_cnt reaches FRAME_HEIGHT → SETTLE.
    - vsync rise while line_cnt < FRAME_HEIGHT: frame_drop pulses 1 cycle, counters clear, stay in CAPTURE (restart), no swap.
  - SETTLE: wait 4 cycles after the last strobe falls → SWAP.
  - SWAP: swap_trigger high exactly 2 cycles, frame_count++, → IDLE.
- Simultaneous events:
  - vsync rise in SETTLE/SWAP is remembered. After SWAP, go directly to CAPTURE instead of IDLE; the frame is not dropped.
  - de fall on the same cycle as the 16th pixel: the word is written first, then counters advance.
- Lines with de pulses shorter than FRAME_WIDTH still count as lines (partial data; no error).
- swap_trigger is a registered output with no glitches; it is low for ≥1 cycle between swaps.

Test Plan:
- Single 128x64 frame, pixel value = {x[7:0], y[7:0], x^y} → 512 strobes, addresses 0..511 in order; at ada=9, din[0][7:0]=0x10 (R of x=16); swap_trigger high for 2 cycles ≥4 cycles after the last strobe; frame_count=1.
- Bank split check: pixel 0 = 0xAABBCC, pixels 1..15 = 0 → first word has din[0][7:0]=0xAA, din[1][7:0]=0xBB, din[2][7:0]=0xCC, upper bits 0.
- Short frame: vsync rise after 10 lines → frame_drop 1-cycle pulse, no swap_trigger, next full frame starts again at ada=0, frame_count unchanged until it completes.
- Oversize line (200-pixel de) and 20-pixel line → exactly 8 writes on the first, 1 write on the second (remaining 4 pixels discarded), line counter advances by 1 each.
- vsync rise during SWAP → swap completes (2 cycles), the next frame is captured without frame_drop.
- rst_n low mid-line for 1 cycle → all outputs 0 immediately (async); after release no strobe until a new vsync rise.
